floo_dma_job_scheduler: RTL and testbench



---
 rtl/floo_dma_job_scheduler.sv | 160 ++++++++++++++++
 tb/tb_floo_dma_job_scheduler.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_dma_job_scheduler.sv
// floo_dma_job_scheduler: launches DMA test-node jobs in index order under a
// concurrency cap, collects completions, drains, and enforces a watchdog.
module floo_dma_job_scheduler #(
  parameter int unsigned NumNodes      = 16,
  parameter int unsigned MaxConcurrent = 4,
  parameter int unsigned DrainCycles   = 1000,
  parameter int unsigned TimeoutCycles = 100000,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  output logic [NumNodes-1:0]           node_en_o,
  input  logic [NumNodes-1:0]           node_done_i,
  output logic                          busy_o,
  output logic                          all_done_o,
  output logic                          timeout_o,
  output logic                          error_o,
  output logic [$clog2(NumNodes+1)-1:0] active_cnt_o,
  output logic [$clog2(NumNodes+1)-1:0] done_cnt_o,
  output logic [CntWidth-1:0]           cycle_cnt_o
);
  localparam int unsigned NW = $clog2(NumNodes + 1);
  localparam int unsigned DW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

  typedef enum logic [2:0] {
    IDLE, DISPATCH, WAIT, DRAIN, DONE, TIMEOUT
  } state_e;

  state_e              state_q, state_d, end_state;
  logic [NW-1:0]       ptr_q, ptr_d;
  logic [NW-1:0]       act_q, act_d;
  logic [NW-1:0]       dcnt_q, dcnt_d;
  logic [NW-1:0]       n_new;
  logic [NumNodes-1:0] en_q, en_d;
  logic [NumNodes-1:0] fin_q, fin_d;
  logic [NumNodes-1:0] new_done;
  logic [CntWidth-1:0] cyc_q, cyc_d, cyc_inc;
  logic [DW-1:0]       drn_q, drn_d;
  logic                err_q, err_d;
  logic                run, restart, launch, all_fin, tmo_hit;

  // A completion is the first cycle a launched node reports done.
  assign new_done = node_done_i & en_q & ~fin_q;
  assign run      = (state_q == DISPATCH) || (state_q == WAIT)
                 || (state_q == DRAIN);
  assign restart  = start_i && !run;
  // Launch uses the registered count; a slot freed now is usable next cycle.
  assign launch   = (state_q == DISPATCH)
                 && (ptr_q < NW'(NumNodes))
                 && (act_q < NW'(MaxConcurrent));
  assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + CntWidth'(1);
  assign tmo_hit  = {1'b0, cyc_inc} >= (CntWidth+1)'(TimeoutCycles);
  assign all_fin  = (dcnt_q + n_new) == NW'(NumNodes);
  assign end_state = (DrainCycles == 0) ? DONE : DRAIN;

  // Popcount of this cycle's new completions.
  always_comb begin
    n_new = '0;
    for (int i = 0; i < int'(NumNodes); i++) begin
      n_new = n_new + NW'(new_done[i]);
    end
  end

  // Next state, launch/completion bookkeeping and watchdog.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    act_d   = act_q;
    dcnt_d  = dcnt_q;
    en_d    = en_q;
    fin_d   = fin_q;
    cyc_d   = cyc_q;
    drn_d   = drn_q;
    err_d   = err_q;
    if (restart) begin
      state_d = DISPATCH;
      ptr_d   = NW'(1);
      en_d    = NumNodes'(1);
      fin_d   = '0;
      act_d   = NW'(1);
      dcnt_d  = '0;
      cyc_d   = '0;
      drn_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (state_q != IDLE && |(node_done_i & ~en_q)) begin
        err_d = 1'b1;
      end
      if (run) begin
        if (launch) begin
          en_d  = en_q | (NumNodes'(1) << ptr_q);
          ptr_d = ptr_q + NW'(1);
        end
        fin_d  = fin_q | new_done;
        act_d  = act_q + NW'(launch) - n_new;
        dcnt_d = dcnt_q + n_new;
        cyc_d  = cyc_inc;
        unique case (state_q)
          DISPATCH, WAIT: begin
            if (state_q == WAIT || ptr_q == NW'(NumNodes)) begin
              if (all_fin) begin
                state_d = end_state;
                drn_d   = '0;
              end else begin
                state_d = WAIT;
              end
            end
          end
          DRAIN: begin
            if (drn_q == DW'(DrainCycles - 1)) begin
              state_d = DONE;
            end else begin
              drn_d = drn_q + DW'(1);
            end
          end
          default: ;
        endcase
        if (tmo_hit) begin
          state_d = TIMEOUT;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      act_q   <= '0;
      dcnt_q  <= '0;
      en_q    <= '0;
      fin_q   <= '0;
      cyc_q   <= '0;
      drn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
      dcnt_q  <= dcnt_d;
      en_q    <= en_d;
      fin_q   <= fin_d;
      cyc_q   <= cyc_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
    end
  end

  assign node_en_o    = en_q;
  assign busy_o       = run;
  assign all_done_o   = (state_q == DONE);
  assign timeout_o    = (state_q == TIMEOUT);
  assign error_o      = err_q;
  assign active_cnt_o = act_q;
  assign done_cnt_o   = dcnt_q;
  assign cycle_cnt_o  = cyc_q;

endmodule

// File: tb/tb_floo_dma_job_scheduler.sv
// tb_floo_dma_job_scheduler: randomized and directed scenarios against a
// job-level reference model of the scheduler.
module tb_floo_dma_job_scheduler;
  localparam int NN = 4;
  localparam int MC = 2;
  localparam int DC = 5;
  localparam int TO = 60;
  localparam int CW = 8;
  localparam int NW = $clog2(NN + 1);
  localparam int OW = NN + 4 + 2 * NW + CW;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [NN-1:0] node_en_o;
  logic [NN-1:0] node_done_i = '0;
  logic busy_o, all_done_o, timeout_o, error_o;
  logic [NW-1:0] active_cnt_o, done_cnt_o;
  logic [CW-1:0] cycle_cnt_o;
  logic [OW-1:0] obs, exp_v;

  always #5 clk = ~clk;

  floo_dma_job_scheduler #(
    .NumNodes(NN), .MaxConcurrent(MC), .DrainCycles(DC),
    .TimeoutCycles(TO), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .node_en_o(node_en_o), .node_done_i(node_done_i),
    .busy_o(busy_o), .all_done_o(all_done_o),
    .timeout_o(timeout_o), .error_o(error_o),
    .active_cnt_o(active_cnt_o), .done_cnt_o(done_cnt_o),
    .cycle_cnt_o(cycle_cnt_o)
  );

  assign obs = {node_en_o, busy_o, all_done_o, timeout_o, error_o,
                active_cnt_o, done_cnt_o, cycle_cnt_o};

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 dispatch, 2 wait, 3 drain, 4 done, 5 timeout.
  int m_phase, m_next, m_cyc, m_drain;
  bit m_l[NN];
  bit m_d[NN];
  bit m_err;
  int m_lc[NN];

  // Node behaviour: absolute raise cycle, or latency after launch.
  int abs_at[NN];
  int lat[NN];
  logic [NN-1:0] spur = '0;
  int cyc = 0;

  task automatic model_out();
    logic [NN-1:0] en;
    int a, d;
    a = 0;
    d = 0;
    for (int i = 0; i < NN; i++) begin
      en[i] = m_l[i];
      if (m_l[i] && !m_d[i]) a++;
      if (m_d[i]) d++;
    end
    exp_v = {en, (m_phase >= 1 && m_phase <= 3), m_phase == 4,
             m_phase == 5, m_err, NW'(a), NW'(d), CW'(m_cyc)};
  endtask

  task automatic model_reset();
    for (int i = 0; i < NN; i++) begin
      m_l[i] = 1'b0;
      m_d[i] = 1'b0;
      m_lc[i] = 0;
    end
    m_phase = 0;
    m_next = 0;
    m_cyc = 0;
    m_drain = 0;
    m_err = 1'b0;
    model_out();
  endtask

  task automatic model_step(input bit st, input logic [NN-1:0] dn);
    int act, nb, d;
    bit lnch;
    if (st && (m_phase == 0 || m_phase >= 4)) begin
      for (int i = 0; i < NN; i++) begin
        m_l[i] = 1'b0;
        m_d[i] = 1'b0;
      end
      m_l[0] = 1'b1;
      m_lc[0] = cyc + 1;
      m_next = 1;
      m_phase = 1;
      m_cyc = 0;
      m_drain = 0;
      m_err = 1'b0;
    end else begin
      if (m_phase != 0)
        for (int i = 0; i < NN; i++)
          if (dn[i] && !m_l[i]) m_err = 1'b1;
      if (m_phase >= 1 && m_phase <= 3) begin
        act = 0;
        for (int i = 0; i < NN; i++)
          if (m_l[i] && !m_d[i]) act++;
        nb = m_next;
        lnch = (m_phase == 1) && (nb < NN) && (act < MC);
        for (int i = 0; i < NN; i++)
          if (dn[i] && m_l[i]) m_d[i] = 1'b1;
        if (lnch) begin
          m_l[nb] = 1'b1;
          m_lc[nb] = cyc + 1;
          m_next++;
        end
        if (m_cyc < (1 << CW) - 1) m_cyc++;
        d = 0;
        for (int i = 0; i < NN; i++)
          if (m_d[i]) d++;
        if (m_phase == 3) begin
          m_drain--;
          if (m_drain == 0) m_phase = 4;
        end else if ((m_phase == 2 || nb == NN) && d == NN) begin
          if (DC == 0) m_phase = 4;
          else begin
            m_phase = 3;
            m_drain = DC;
          end
        end else if (m_phase == 1 && nb == NN) begin
          m_phase = 2;
        end
        if (m_cyc >= TO) m_phase = 5;
      end
    end
    model_out();
  endtask

  task automatic set_policy(input int l0, l1, l2, l3,
                            input int a0, a1, a2, a3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    abs_at[0] = a0; abs_at[1] = a1; abs_at[2] = a2; abs_at[3] = a3;
  endtask

  // Drive one cycle of inputs, advance the model, land on the next negedge.
  task automatic step(input bit st);
    logic [NN-1:0] dn;
    bit rs;
    rs = st && (m_phase == 0 || m_phase >= 4);
    if (rs) cyc = 0;
    dn = '0;
    if (!rs)
      for (int i = 0; i < NN; i++)
        if ((abs_at[i] >= 0 && cyc >= abs_at[i]) ||
            (lat[i] >= 0 && m_l[i] && cyc >= m_lc[i] + lat[i]) ||
            spur[i])
          dn[i] = 1'b1;
    spur = '0;
    start_i = st;
    node_done_i = dn;
    model_step(st, dn);
    @(negedge clk);
    cyc++;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs !== exp_v || obs !== '0) begin
        $display("FAIL reset: got %h want %h", obs, exp_v);
        miscompares++;
      end
      @(negedge clk);
    end
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      vectors++;
      if (obs !== exp_v) begin
        $display("FAIL idle: got %h want %h", obs, exp_v);
        miscompares++;
      end
    end
  endtask

  task automatic test_basic();
    int fe[NN];
    int want[NN];
    int fd;
    want = '{1, 2, 6, 7};
    fe = '{-1, -1, -1, -1};
    fd = -1;
    set_policy(3, 3, 3, 3, -1, -1, -1, -1);
    step(1'b1);
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (obs !== exp_v) begin
        $display("FAIL basic c%0d: got %h want %h", cyc, obs, exp_v);
        miscompares++;
      end
      for (int i = 0; i < NN; i++)
        if (node_en_o[i] && fe[i] < 0) fe[i] = cyc;
      if (all_done_o && fd < 0) fd = cyc;
      if (cyc == 6) begin
        vectors++;
        if (active_cnt_o !== NW'(1)) begin
          $display("FAIL basic_same_cycle: got %0d want 1", active_cnt_o);
          miscompares++;
        end
      end
      step(1'b0);
    end
    for (int i = 0; i < NN; i++) begin
      vectors++;
      if (fe[i] != want[i]) begin
        $display("FAIL basic_en%0d: got %0d want %0d", i, fe[i], want[i]);
        miscompares++;
      end
    end
    vectors++;
    if (fd != 16) begin
      $display("FAIL basic_done_cycle: got %0d want 16", fd);
      miscompares++;
    end
  endtask

  task automatic test_throttle();
    int fe[NN];
    int fd, mx;
    fe = '{-1, -1, -1, -1};
    fd = -1;
    mx = 0;
    set_policy(-1, -1, -1, -1, 10, 15, 25, 25);
    step(1'b1);
    for (int k = 0; k < 34; k++) begin
      vectors++;
      if (obs !== exp_v) begin
        $display("FAIL throttle c%0d: got %h want %h", cyc, obs, exp_v);
        miscompares++;
      end
      for (int i = 0; i < NN; i++)
        if (node_en_o[i] && fe[i] < 0) fe[i] = cyc;
      if (all_done_o && fd < 0) fd = cyc;
      if (int'(active_cnt_o) > mx) mx = int'(active_cnt_o);
      if (cyc == 26) begin
        vectors++;
        if (done_cnt_o !== NW'(4)) begin
          $display("FAIL throttle_multi: got %0d want 4", done_cnt_o);
          miscompares++;
        end
      end
      step(1'b0);
    end
    vectors++;
    if (fe[2] != 12 || fe[3] != 17) begin
      $display("FAIL throttle_en: got %0d/%0d want 12/17", fe[2], fe[3]);
      miscompares++;
    end
    vectors++;
    if (mx != MC) begin
      $display("FAIL throttle_cap: got %0d want %0d", mx, MC);
      miscompares++;
    end
    vectors++;
    if (fd != 31) begin
      $display("FAIL throttle_done: got %0d want 31", fd);
      miscompares++;
    end
  endtask

  task automatic test_spurious();
    set_policy(2, 2, 2, 2, -1, -1, -1, -1);
    step(1'b1);
    for (int k = 0; k < 30; k++) begin
      vectors++;
      if (obs !== exp_v) begin
        $display("FAIL spurious c%0d: got %h want %h", cyc, obs, exp_v);
        miscompares++;
      end
      if (cyc == 2) begin
        vectors++;
        if (error_o !== 1'b0) begin
          $display("FAIL spurious_pre: got %b want 0", error_o);
          miscompares++;
        end
        spur = 4'b1000;
      end
      if (cyc == 3) begin
        vectors++;
        if (error_o !== 1'b1 || done_cnt_o !== NW'(0)) begin
          $display("FAIL spurious_flag: got %b/%0d want 1/0",
                   error_o, done_cnt_o);
          miscompares++;
        end
      end
      step(1'b0);
    end
    vectors++;
    if (error_o !== 1'b1 || done_cnt_o !== NW'(4) || all_done_o !== 1'b1) begin
      $display("FAIL spurious_end: got %b/%0d/%b want 1/4/1",
               error_o, done_cnt_o, all_done_o);
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    int ft;
    ft = -1;
    set_policy(2, 2, -1, 2, -1, -1, -1, -1);
    step(1'b1);
    for (int k = 0; k < 66; k++) begin
      vectors++;
      if (obs !== exp_v) begin
        $display("FAIL timeout c%0d: got %h want %h", cyc, obs, exp_v);
        miscompares++;
      end
      if (timeout_o && ft < 0) ft = cyc;
      step(1'b0);
    end
    vectors++;
    if (ft != TO + 1) begin
      $display("FAIL timeout_cycle: got %0d want %0d", ft, TO + 1);
      miscompares++;
    end
    vectors++;
    if (cycle_cnt_o !== CW'(TO) || all_done_o !== 1'b0 ||
        busy_o !== 1'b0 || node_en_o !== 4'b1111) begin
      $display("FAIL timeout_hold: got cnt %0d done %b busy %b en %b",
               cycle_cnt_o, all_done_o, busy_o, node_en_o);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int r = 0; r < 2; r++) begin
      set_policy($urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 5), $urandom_range(0, 5),
                 -1, -1, -1, -1);
      step(1'b1);
      vectors++;
      if (node_en_o !== 4'b0001 || error_o !== 1'b0 ||
          cycle_cnt_o !== CW'(0)) begin
        $display("FAIL b2b_restart: got en %b err %b cnt %0d",
                 node_en_o, error_o, cycle_cnt_o);
        miscompares++;
      end
      n = 0;
      while (!all_done_o && n < 60) begin
        step(n == 2);
        n++;
        vectors++;
        if (obs !== exp_v) begin
          $display("FAIL b2b c%0d: got %h want %h", cyc, obs, exp_v);
          miscompares++;
        end
      end
      vectors++;
      if (all_done_o !== 1'b1) begin
        $display("FAIL b2b_bound: got done %b want 1", all_done_o);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    set_policy(-1, -1, -1, -1, -1, -1, -1, -1);
    step(1'b1);
    while (cyc < 8) begin
      vectors++;
      if (obs !== exp_v) begin
        $display("FAIL rstmid c%0d: got %h want %h", cyc, obs, exp_v);
        miscompares++;
      end
      step(1'b0);
    end
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (obs !== '0) begin
      $display("FAIL rstmid_async: got %h want 0", obs);
      miscompares++;
    end
    @(negedge clk);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0);
    vectors++;
    if (obs !== exp_v || node_en_o !== 4'b0000) begin
      $display("FAIL rstmid_idle: got %h want %h", obs, exp_v);
      miscompares++;
    end
    step(1'b1);
    vectors++;
    if (node_en_o !== 4'b0001 || obs !== exp_v) begin
      $display("FAIL rstmid_start: got %b want 0001", node_en_o);
      miscompares++;
    end
  endtask

  task automatic test_random();
    int l[NN];
    int tail;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NN; i++)
        l[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 8));
      set_policy(l[0], l[1], l[2], l[3], -1, -1, -1, -1);
      step(1'b1);
      tail = 0;
      for (int k = 0; k < 80 && tail < 3; k++) begin
        vectors++;
        if (obs !== exp_v) begin
          $display("FAIL random r%0d c%0d: got %h want %h",
                   r, cyc, obs, exp_v);
          miscompares++;
        end
        vectors++;
        if (active_cnt_o > NW'(MC)) begin
          $display("FAIL random_cap: got %0d want <=%0d", active_cnt_o, MC);
          miscompares++;
        end
        if ($urandom_range(0, 15) == 0)
          spur[$urandom_range(0, NN - 1)] = 1'b1;
        if (m_phase >= 4) tail++;
        step(m_phase < 4 && $urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    model_reset();
    set_policy(-1, -1, -1, -1, -1, -1, -1, -1);
    @(negedge clk);
    test_reset();
    test_basic();
    test_throttle();
    test_spurious();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
